multdiv_sequencer: RTL
======================

// Module: multdiv_sequencer
// PURPOSE
//  Top-level sequencer for the shared multiply/divide datapath of the processor.
//  - Accepts one-cycle ctrl_MULT / ctrl_DIV requests from the pipeline.
//  - Latches the operands and issues a one-cycle start pulse to the mult or div unit.
//  - Watches that unit's ready and returns result, exception and a one-cycle data_resultRDY.
//  - Screens divide-by-zero and hung units (watchdog) so the pipeline stall always ends.
// PARAMETERS
//  WIDTH    32  operand/result width
//  TIMEOUT  40  max cycles in a RUN state before forced completion; div unit finishes in 33
//  CNTW     6   watchdog counter width; must satisfy 2^CNTW > TIMEOUT
// PORTS
//  clock           in   1      rising-edge clock
//  reset           in   1      asynchronous, active-high reset
//  ctrl_MULT       in   1      multiply request, one-cycle pulse
//  ctrl_DIV        in   1      divide request, one-cycle pulse
//  data_operandA   in   WIDTH  operand A (multiplicand / dividend)
//  data_operandB   in   WIDTH  operand B (multiplier / divisor)
//  mult_ready      in   1      multiply unit done
//  mult_result     in   WIDTH  multiply unit product, low word
//  mult_overflow   in   1      multiply unit overflow flag
//  div_ready       in   1      divide unit done
//  div_result      in   WIDTH  divide unit quotient
//  op_A            out  WIDTH  latched operand A to both units
//  op_B            out  WIDTH  latched operand B to both units
//  mult_start      out  1      one-cycle start to multiply unit
//  div_start       out  1      one-cycle start to divide unit
//  data_result     out  WIDTH  final result, held until next request
//  data_exception  out  1      valid with data_resultRDY, held with data_result
//  data_resultRDY  out  1      one-cycle completion strobe
//  busy            out  1      high in MULT_RUN/DIV_RUN; pipeline stall source
// BEHAVIOUR
//  States: IDLE, MULT_RUN, DIV_RUN, DONE. Reset forces IDLE.
//  Reset values: every output and the watchdog counter are 0.
//  Request sampling: a request is sampled at any rising edge N, in any state, including RUN.
//   - ctrl_MULT only: latch A/B into op_A/op_B, mult_start=1 for the cycle after N,
//     counter cleared, state MULT_RUN.
//   - ctrl_DIV only, B!=0: same as above with div_start, state DIV_RUN.
//   - ctrl_DIV only, B==0: no start pulse; state DONE with result 0, exception 1.
//   - ctrl_MULT and ctrl_DIV together: no start pulse; state DONE with result 0, exception 1.
//  New request while in a RUN state: the current operation is aborted and produces no
//   RDY strobe. The new request is handled exactly as if issued from IDLE.
//  RUN states: the counter increments every edge. start is deasserted after its single cycle.
//   - Selected unit's ready sampled 1 at an edge: capture the result at that edge,
//     state DONE.
//     - MULT: exception = mult_overflow.
//     - DIV: exception = 0.
//   - The unselected unit's ready is ignored.
//   - Counter reaches TIMEOUT with no ready: state DONE with result 0, exception 1.
//  DONE: data_resultRDY=1 for exactly one cycle, then IDLE.
//   - A request arriving while in DONE is still accepted; RDY for the finished operation
//     is not suppressed.
//  data_result and data_exception are registered. They change only on entry to DONE and on
//   reset.
//  Latency: request at edge N, unit ready sampled at edge M -> data_resultRDY high during
//   cycle M+1. A div-by-zero request at edge N gives RDY during cycle N+1.
//  Asynchronous reset mid-operation: returns to IDLE immediately.
//   - All strobes and busy drop; data_result clears to 0.
//   - Late ready pulses from the units are ignored in IDLE.
// TESTING
//  1. Mult: A=7, B=6 at edge 0; model asserts mult_ready with 42 at edge 10
//     -> mult_start high 1 cycle, RDY at cycle 11, result 42, exc 0.
//  2. Div: A=100, B=7; div unit ready with 14 at edge 33
//     -> div_start one cycle, busy 33 cycles, result 14, exc 0.
//  3. Div-by-zero: A=5, B=0 -> no div_start, RDY next cycle, result 0, exc 1.
//  4. Mult with mult_overflow=1 at ready, result 0x00000000
//     -> RDY, exc 1. Also both ctrl lines high together -> RDY next cycle, exc 1.
//  5. Abort: ctrl_DIV, then ctrl_MULT 5 cycles later (A=3, B=3)
//     -> one RDY only, result 9; div_ready pulse in MULT_RUN ignored.
//  6. Watchdog: ready never asserted -> RDY when counter hits TIMEOUT, exc 1.
//     Also reset asserted mid-DIV_RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Sequencer for the shared multiply/divide datapath. A one-cycle ctrl_MULT or
//   ctrl_DIV request latches the operands and fires a one-cycle start to the
//   selected unit. The sequencer then waits for that unit's ready and returns
//   the result with a one-cycle data_resultRDY strobe. Divide-by-zero, a
//   simultaneous MULT+DIV request, and a unit that never answers (watchdog)
//   all complete with result 0 and exception 1, so a pipeline stall always ends.
//
// Ports
//   clock, reset                      rising-edge clock, async active-high reset
//   ctrl_MULT, ctrl_DIV               one-cycle operation requests
//   data_operandA, data_operandB      request operands
//   mult_ready/result/overflow        multiply unit handshake and result
//   div_ready/result                  divide unit handshake and result
//   op_A, op_B                        latched operands to both units
//   mult_start, div_start             one-cycle unit start pulses
//   data_result, data_exception       completed result, held until next completion
//   data_resultRDY                    one-cycle completion strobe
//   busy                              high while a unit is running (stall source)
module multdiv_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNTW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             mult_ready,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_overflow,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] op_A,
    output logic [WIDTH-1:0] op_B,
    output logic             mult_start,
    output logic             div_start,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             mult_start_q;
    logic             div_start_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic req_any;
    logic req_bad;
    logic timeout_hit;

    // A request is illegal when both lines fire together or a divide has a zero divisor.
    assign req_any     = ctrl_MULT | ctrl_DIV;
    assign req_bad     = (ctrl_MULT & ctrl_DIV) | (ctrl_DIV & (data_operandB == '0));
    // Counter is about to reach TIMEOUT on this edge.
    assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            result_q     <= '0;
            exc_q        <= 1'b0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            rdy_q        <= 1'b0;

            // A new request wins over everything, including a ready arriving on
            // the same edge; an in-flight operation is abandoned without a strobe.
            if (req_any) begin
                cnt_q <= '0;
                if (req_bad) begin
                    state_q  <= DONE;
                    result_q <= '0;
                    exc_q    <= 1'b1;
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                end else begin
                    op_a_q <= data_operandA;
                    op_b_q <= data_operandB;
                    busy_q <= 1'b1;
                    if (ctrl_MULT) begin
                        mult_start_q <= 1'b1;
                        state_q      <= MULT_RUN;
                    end else begin
                        div_start_q <= 1'b1;
                        state_q     <= DIV_RUN;
                    end
                end
            end else begin
                case (state_q)
                    MULT_RUN: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (mult_ready) begin
                            state_q  <= DONE;
                            result_q <= mult_result;
                            exc_q    <= mult_overflow;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end else if (timeout_hit) begin
                            state_q  <= DONE;
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end
                    DIV_RUN: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (div_ready) begin
                            state_q  <= DONE;
                            result_q <= div_result;
                            exc_q    <= 1'b0;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end else if (timeout_hit) begin
                            state_q  <= DONE;
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign op_A           = op_a_q;
    assign op_B           = op_b_q;
    assign mult_start     = mult_start_q;
    assign div_start      = div_start_q;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
